// File: rtl/sram_master_if.sv
// ============================================================================
// sram_master_if : request/response handshake between bus logic and sram_master
// Rev 1.0
// ============================================================================
`default_nettype none

interface sram_master_if #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

`default_nettype wire

// File: rtl/sram_master.sv
// ============================================================================
// sram_master : turns single read/write requests into SETUP/STROBE/HOLD cycles
//               on an asynchronous byte-wide SRAM. Rev 1.0
// ============================================================================
`default_nettype none

module sram_master #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 11,
   parameter int SETUP_CYCLES = 1,
   parameter int PULSE_CYCLES = 2,
   parameter int HOLD_CYCLES  = 1
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   sram_master_if.slave               bus,
   output      logic [ADDR_WIDTH-1:0] sram_address_o,
   output      logic [DATA_WIDTH-1:0] sram_data_out_o,
   output      logic                  sram_data_oe_o,
   input  wire logic [DATA_WIDTH-1:0] sram_data_in_i,
   output      logic                  sram_write_enable_o,
   output      logic                  sram_output_enable_o
);

   localparam logic [3:0] SETUP_LD = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] PULSE_LD = 4'(PULSE_CYCLES - 1);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic                  wr_q;
   logic                  ready_q;
   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  doe_q;
   logic                  we_n_q;
   logic                  oe_n_q;

   // Address and write data live in the output registers themselves, so they
   // stay put in IDLE and through HOLD without extra copies.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         wr_q        <= 1'b0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         addr_q      <= '0;
         dout_q      <= '0;
         doe_q       <= 1'b0;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.req_valid && ready_q) begin
                  state_q <= ST_SETUP;
                  cnt_q   <= SETUP_LD;
                  wr_q    <= bus.req_write;
                  ready_q <= 1'b0;
                  addr_q  <= bus.req_addr;
                  doe_q   <= bus.req_write;
                  if (bus.req_write) begin
                     dout_q <= bus.req_wdata;
                  end
               end
            end
            ST_SETUP: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_STROBE;
                  cnt_q   <= PULSE_LD;
                  we_n_q  <= ~wr_q;
                  oe_n_q  <= wr_q;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_STROBE: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_HOLD;
                  cnt_q   <= HOLD_LD;
                  we_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  if (!wr_q) begin
                     rdata_q     <= sram_data_in_i;
                     rsp_valid_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_HOLD: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b1;
                  doe_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
               doe_q   <= 1'b0;
               we_n_q  <= 1'b1;
               oe_n_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.req_ready        = ready_q;
   assign bus.rsp_valid        = rsp_valid_q;
   assign bus.rsp_rdata        = rdata_q;
   assign sram_address_o       = addr_q;
   assign sram_data_out_o      = dout_q;
   assign sram_data_oe_o       = doe_q;
   assign sram_write_enable_o  = we_n_q;
   assign sram_output_enable_o = oe_n_q;

endmodule

`default_nettype wire

// File: doc/sram_master.md
# sram_master

Synchronous initiator for the asynchronous byte-wide SRAM used throughout the design (active-low write strobe, active-low output enable, separate data-in/data-out paths). It accepts single read or write requests on a valid/ready handshake in the system clock domain and turns each into a fixed, parameterised SETUP/STROBE/HOLD strobe sequence on the SRAM pins. Read data is returned as a one-cycle response pulse. It sits between the CPU/sound-engine bus logic and each external or modelled SRAM instance.

## Interface
- DATA_WIDTH, 8, data bus width
- ADDR_WIDTH, 11, address width (2048 locations)
- SETUP_CYCLES, 1, cycles address (and write data) are stable before the strobe; legal range 1..15
- PULSE_CYCLES, 2, cycles WE#/OE# is held low; legal range 1..15
- HOLD_CYCLES, 1, cycles address/data held after strobe release; legal range 1..15

- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  target address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse: rsp_rdata holds read data
- rsp_rdata  out  DATA_WIDTH  last read data; holds until next read response
- sram_address  out  ADDR_WIDTH  SRAM address pins
- sram_data_out  out  DATA_WIDTH  data to SRAM data input
- sram_data_oe  out  1  1 = sram_data_out is driven (write in progress)
- sram_data_in  in  DATA_WIDTH  data from SRAM data output
- sram_write_enable  out  1  SRAM WE#, active-low
- sram_output_enable  out  1  SRAM OE#, active-low

## Operation
- Single FSM: IDLE, SETUP, STROBE, HOLD; 4-bit down-counter loaded on each state entry with (param − 1).
- IDLE: req_ready=1. On req_valid && req_ready: latch req_write/req_addr/req_wdata into internal registers, go to SETUP. Request inputs ignored outside the handshake cycle.
- SETUP: sram_address = latched address; strobes both high; for writes sram_data_oe=1 and sram_data_out = latched data. Leaves after SETUP_CYCLES cycles.
- STROBE: read → OE# low, WE# high; write → WE# low, OE# high. Leaves after PULSE_CYCLES cycles. On the final STROBE clock edge of a read, sram_data_in is captured into rsp_rdata.
- HOLD: both strobes high; address and (writes) data/oe unchanged. Leaves after HOLD_CYCLES cycles to IDLE.
- WE# and OE# never low in the same cycle; neither strobe low outside STROBE.
- sram_data_oe is 1 for all SETUP/STROBE/HOLD cycles of a write, 0 otherwise (reads, IDLE, reset).
- sram_address and sram_data_out retain their last values in IDLE (no glitch to 0).
- X/Z on sram_data_in is captured as-is; no checking.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, sram_address=0, sram_data_out=0, sram_data_oe=0, sram_write_enable=1, sram_output_enable=1; FSM=IDLE. Assertion mid-transaction forces these immediately (asynchronously): an in-flight write strobe is cut short, an in-flight read produces no response.
- Handshake at edge N: SETUP cycles N+1..N+S, STROBE N+S+1..N+S+P, HOLD N+S+P+1..N+S+P+H, req_ready high again at N+S+P+H+1 (S,P,H = SETUP/PULSE/HOLD_CYCLES).
- Read: rsp_valid high exactly in cycle N+S+P+1 (first HOLD cycle); data = sram_data_in sampled at the last STROBE edge. Writes never raise rsp_valid.
- Throughput: one transaction per S+P+H+1 cycles (defaults: 5); back-to-back requests accepted on the first IDLE cycle.

## Test plan
- Reset: hold rst_n=0, then release -> all outputs at reset values, req_ready=1, WE#=OE#=1.
- Write addr 0x155 data 0xA5, defaults -> WE# low exactly 2 cycles, address 0x155 and data 0xA5 with oe=1 from cycle N+1 through N+4, OE# stays high, no rsp_valid; model memory location 0x155 = 0xA5.
- Read addr 0x155 after the write -> OE# low cycles N+2..N+3, rsp_valid single pulse at N+4 with rsp_rdata=0xA5, sram_data_oe=0 throughout.
- Back-to-back: write 0x7FF=0x3C then read 0x7FF with req_valid held high -> second handshake exactly 5 cycles after the first, read returns 0x3C; WE#/OE# never both low.
- Parameters S=3,P=4,H=2: read addr 0x001 -> OE# low exactly 4 cycles starting at N+4, rsp_valid at N+8, req_ready back at N+10.
- Reset mid-write (rst_n low during second STROBE cycle) -> WE# returns high and sram_data_oe=0 in the same cycle without a clock edge, FSM in IDLE after release, next read completes normally.
